softreg_responder: RTL and testbench
====================================

SOFTREG_RESPONDER -- requirements
Module: softreg_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, softreg address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, softreg data width.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count (2..256).
REQ-004 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port io_softreg_req_valid  in  1  host request valid.
REQ-007 SHALL have port io_softreg_req_ready  out  1  responder accepts request.
REQ-008 SHALL have port io_softreg_req_bits_addr  in  ADDR_WIDTH  register index.
REQ-009 SHALL have port io_softreg_req_bits_wdata  in  DATA_WIDTH  write data.
REQ-010 SHALL have port io_softreg_req_bits_wr  in  1  1=write, 0=read.
REQ-011 SHALL have port io_softreg_resp_valid  out  1  read data valid.
REQ-012 SHALL have port io_softreg_resp_ready  in  1  host accepts read data.
REQ-013 SHALL have port io_softreg_resp_bits_rdata  out  DATA_WIDTH  read data.
REQ-014 SHALL have port regs_out  out  NUM_REGS*DATA_WIDTH  flat register file, reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-015 SHALL have port wr_pulse  out  1  one-cycle strobe per committed in-range write.
REQ-016 SHALL have port wr_index  out  8  index of the write flagged by wr_pulse.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and RESP.
REQ-018 SHALL drive io_softreg_req_ready=1 in IDLE and 0 in RESP.
REQ-019 SHALL define accept as req_valid && req_ready on a rising edge.
REQ-020 SHALL, on an accepted write with addr < NUM_REGS, update reg[addr] at that edge, visible on regs_out next cycle, and pulse wr_pulse with wr_index=addr in the following cycle only.
REQ-021 SHALL return no response for writes; FSM stays IDLE (back-to-back writes, one per cycle).
REQ-022 SHALL, on an accepted read, capture rdata and enter RESP; resp_valid=1 the next cycle (latency 1).
REQ-023 SHALL hold resp_valid and rdata stable in RESP until resp_ready=1, then return to IDLE next cycle (read throughput one per two cycles).
REQ-024 SHALL return reg[addr] for reads with addr < NUM_REGS.
REQ-025 SHALL map addr == NUM_REGS to the status register: read returns zero-extended 16-bit err_cnt; write clears err_cnt to 0 regardless of wdata.
REQ-026 SHALL treat addr > NUM_REGS as illegal: read returns 0, write is dropped, both increment err_cnt.
REQ-027 SHALL saturate err_cnt at 0xFFFF (no wrap).
REQ-028 SHALL compare full ADDR_WIDTH address; upper bits are never truncated.
REQ-029 SHALL ignore req_valid while in RESP (no accept, no state change).
REQ-030 SHALL keep resp_valid=0 and wr_pulse=0 in every cycle not specified above.

Reset
REQ-031 SHALL, on any edge with reset=0, force FSM=IDLE, all regs=0, err_cnt=0, resp_valid=0, rdata=0, wr_pulse=0, wr_index=0.
REQ-032 SHALL drop a pending response when reset asserts in RESP; no stale response after deassertion.
REQ-033 SHALL hold req_ready=0 during reset and assert it the first cycle after reset=1.

Structure
REQ-034 SHALL place the FSM state enum, STATUS_ERR_WIDTH=16 and the illegal-read value (0) in shared package softreg_pkg.
REQ-035 SHALL instantiate one sub-module, softreg_regfile (NUM_REGS x DATA_WIDTH, one write port, one combinational read port); FSM, status and error logic stay in the top.

Verification
REQ-036 SHALL test: write 0x1122334455667788 to addr 3 -> regs_out[3] equals it next cycle, wr_pulse=1 wr_index=3 exactly one cycle, no resp_valid.
REQ-037 SHALL test: read addr 3 with resp_ready held 0 for 5 cycles -> resp_valid=1 from cycle 1, rdata=0x1122334455667788 stable, req_ready=0 throughout, IDLE one cycle after resp_ready=1.
REQ-038 SHALL test: write addr 40, read addr 99 (NUM_REGS=16) -> read returns 0; read addr 16 returns 2; write addr 16 then read 16 returns 0.
REQ-039 SHALL test: 70000 illegal writes -> status read returns 0xFFFF.
REQ-040 SHALL test: reset=0 for one cycle while in RESP -> resp_valid=0 next cycle, regs_out all 0, req_ready=1 once reset=1.
REQ-041 SHALL test: writes to addrs 0..15 on 16 consecutive cycles -> all accepted, 16 wr_pulses, each reg correct.

Source files
------------

// File: rtl/softreg_pkg.sv
// Shared definitions for the softreg responder and its register file.
//   - FSM state encoding (IDLE / RESP) as legacy-compatible constants
//   - Width of the saturating error counter exposed through the status register
//   - Value returned for reads of illegal addresses
//   - Saturating increment helper for the error counter
package softreg_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RESP = 1'b1;

    localparam int STATUS_ERR_WIDTH = 16;

    localparam int ILLEGAL_READ_VALUE = 0;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [STATUS_ERR_WIDTH-1:0] err_sat_inc(
        input logic [STATUS_ERR_WIDTH-1:0] cnt
    );
        return (&cnt) ? cnt : cnt + STATUS_ERR_WIDTH'(1);
    endfunction

endpackage

// File: rtl/softreg_regfile.sv
// Register file behind the softreg responder.
//   clock      : rising-edge clock
//   reset      : synchronous active-low clear of every register
//   wr_en      : write strobe for wr_index/wr_data
//   wr_index   : register written when wr_en is high
//   wr_data    : data written
//   rd_index   : combinational read index
//   rd_data    : contents of register rd_index (0 when out of range)
//   regs_flat  : all registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
module softreg_regfile
    import softreg_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 64,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [IDX_WIDTH-1:0]           wr_index,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [IDX_WIDTH-1:0]           rd_index,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_index] <= wr_data;
        end
    end

    // For non-power-of-two register counts the index can name a missing
    // register; return zero rather than an undefined array element.
    assign rd_data = (32'(rd_index) < NUM_REGS) ? mem[rd_index] : '0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
    end

endmodule

// File: rtl/softreg_responder.sv
// Softreg responder: host-facing request/response front end for a small
// register file, with a status register that reports illegal accesses.
//   clock / reset                 : rising-edge clock, synchronous active-low reset
//   io_softreg_req_*              : host request (valid/ready, addr, wdata, wr)
//   io_softreg_resp_*             : read response (valid/ready, rdata)
//   regs_out                      : flat view of every register
//   wr_pulse / wr_index           : one-cycle strobe and index per committed write
// Address NUM_REGS is the status register (reads return the error count,
// writes clear it); any higher address is illegal and bumps the count.
module softreg_responder
    import softreg_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           io_softreg_req_valid,
    output logic                           io_softreg_req_ready,
    input  logic [ADDR_WIDTH-1:0]          io_softreg_req_bits_addr,
    input  logic [DATA_WIDTH-1:0]          io_softreg_req_bits_wdata,
    input  logic                           io_softreg_req_bits_wr,
    output logic                           io_softreg_resp_valid,
    input  logic                           io_softreg_resp_ready,
    output logic [DATA_WIDTH-1:0]          io_softreg_resp_bits_rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic                           wr_pulse,
    output logic [7:0]                     wr_index
);

    localparam int IDX_WIDTH = $clog2(NUM_REGS);

    // One extra bit keeps the comparison exact even when NUM_REGS does not
    // fit in ADDR_WIDTH bits; the full address always takes part.
    localparam logic [ADDR_WIDTH:0] NUM_REGS_EXT = (ADDR_WIDTH+1)'(NUM_REGS);

    state_t                      state;
    logic [STATUS_ERR_WIDTH-1:0] err_cnt;
    logic [DATA_WIDTH-1:0]       rdata;

    logic [ADDR_WIDTH:0]   addr_ext;
    logic                  addr_in_range;
    logic                  addr_is_status;
    logic                  addr_illegal;
    logic [IDX_WIDTH-1:0]  reg_index;
    logic                  accept;
    logic                  reg_wr_en;
    logic [DATA_WIDTH-1:0] reg_rd_data;
    logic [DATA_WIDTH-1:0] read_value;

    assign addr_ext       = {1'b0, io_softreg_req_bits_addr};
    assign addr_in_range  = addr_ext < NUM_REGS_EXT;
    assign addr_is_status = addr_ext == NUM_REGS_EXT;
    assign addr_illegal   = !addr_in_range && !addr_is_status;
    assign reg_index      = io_softreg_req_bits_addr[IDX_WIDTH-1:0];

    // Ready is masked by reset so the host never sees a request taken while
    // the responder is being cleared.
    assign io_softreg_req_ready = reset && (state == ST_IDLE);
    assign accept               = io_softreg_req_valid && io_softreg_req_ready;
    assign reg_wr_en            = accept && io_softreg_req_bits_wr && addr_in_range;

    softreg_regfile #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_regfile (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (reg_wr_en),
        .wr_index  (reg_index),
        .wr_data   (io_softreg_req_bits_wdata),
        .rd_index  (reg_index),
        .rd_data   (reg_rd_data),
        .regs_flat (regs_out)
    );

    // Read data source chosen by address class.
    always_comb begin
        read_value = DATA_WIDTH'(ILLEGAL_READ_VALUE);
        if (addr_in_range) begin
            read_value = reg_rd_data;
        end else if (addr_is_status) begin
            read_value = DATA_WIDTH'(err_cnt);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            err_cnt  <= '0;
            rdata    <= '0;
            wr_pulse <= 1'b0;
            wr_index <= '0;
        end else begin
            wr_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (io_softreg_req_bits_wr) begin
                            if (addr_in_range) begin
                                wr_pulse <= 1'b1;
                                wr_index <= 8'(reg_index);
                            end else if (addr_is_status) begin
                                err_cnt <= '0;
                            end else begin
                                err_cnt <= err_sat_inc(err_cnt);
                            end
                        end else begin
                            rdata <= read_value;
                            state <= ST_RESP;
                            if (addr_illegal) begin
                                err_cnt <= err_sat_inc(err_cnt);
                            end
                        end
                    end
                end
                ST_RESP: begin
                    if (io_softreg_resp_ready) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign io_softreg_resp_valid      = (state == ST_RESP);
    assign io_softreg_resp_bits_rdata = rdata;

endmodule

// File: tb/tb_softreg_responder.sv
// Self-checking bench for softreg_responder: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// register file and error counter kept here.
module tb_softreg_responder;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int NR = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic              req_wr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DW-1:0]     resp_rdata;
    logic [NR*DW-1:0]  regs_out;
    logic              wr_pulse;
    logic [7:0]        wr_index;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] model_regs [NR];
    int            model_err;

    always #5 clock = ~clock;

    softreg_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR)
    ) dut (
        .clock                      (clock),
        .reset                      (reset),
        .io_softreg_req_valid       (req_valid),
        .io_softreg_req_ready       (req_ready),
        .io_softreg_req_bits_addr   (req_addr),
        .io_softreg_req_bits_wdata  (req_wdata),
        .io_softreg_req_bits_wr     (req_wr),
        .io_softreg_resp_valid      (resp_valid),
        .io_softreg_resp_ready      (resp_ready),
        .io_softreg_resp_bits_rdata (resp_rdata),
        .regs_out                   (regs_out),
        .wr_pulse                   (wr_pulse),
        .wr_index                   (wr_index)
    );

    // Compare one observed value against the model's expectation.
    task automatic check_output(input string tag, input logic [DW-1:0] observed,
                                input logic [DW-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) model_regs[i] = '0;
        model_err = 0;
    endtask

    // Behavioural model of one accepted access; returns the read value.
    function automatic logic [DW-1:0] model_access(input logic [AW-1:0] a, input logic w,
                                                   input logic [DW-1:0] d);
        logic [DW-1:0] r;
        r = '0;
        if (a < NR) begin
            if (w) model_regs[a] = d;
            else   r = model_regs[a];
        end else if (a == NR) begin
            if (w) model_err = 0;
            else   r = 64'(model_err);
        end else begin
            if (model_err < 65535) model_err++;
        end
        return r;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            check_output($sformatf("%s_reg%0d", tag, i), regs_out[i*DW +: DW], model_regs[i]);
        end
    endtask

    // Single accepted write, then check strobe and register update.
    task automatic apply_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        check_output("wr_req_ready", 64'(req_ready), 64'd1);
        tick();
        void'(model_access(a, 1'b1, d));
        req_valid = 1'b0;
        check_output("wr_pulse", 64'(wr_pulse), 64'(a < NR));
        if (a < NR) begin
            check_output("wr_index", 64'(wr_index), 64'(a));
            check_output("wr_reg", regs_out[int'(a[7:0])*DW +: DW], d);
        end
        check_output("wr_resp_valid", 64'(resp_valid), 64'd0);
    endtask

    // Read with resp_ready held low for 'hold' extra cycles while stray
    // requests are presented; they must all be ignored.
    task automatic apply_read(input logic [AW-1:0] a, input int hold, output logic [DW-1:0] got);
        logic [DW-1:0] expected;
        req_valid  = 1'b1;
        req_wr     = 1'b0;
        req_addr   = a;
        resp_ready = 1'b0;
        check_output("rd_req_ready", 64'(req_ready), 64'd1);
        tick();
        expected  = model_access(a, 1'b0, '0);
        req_valid = 1'b0;
        got       = resp_rdata;
        for (int c = 0; c <= hold; c++) begin
            check_output("rd_resp_valid", 64'(resp_valid), 64'd1);
            check_output("rd_rdata", resp_rdata, expected);
            check_output("rd_busy_ready", 64'(req_ready), 64'd0);
            check_output("rd_wr_pulse", 64'(wr_pulse), 64'd0);
            if (c < hold) begin
                req_valid = 1'b1;
                req_wr    = 1'($urandom_range(0, 1));
                req_addr  = AW'($urandom_range(0, NR - 1));
                req_wdata = {$urandom, $urandom};
                tick();
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check_output("rd_done_valid", 64'(resp_valid), 64'd0);
        check_output("rd_done_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [DW-1:0] got;
        logic [AW-1:0] a;
        int            pulses;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        model_clear();

        // Reset state
        tick();
        tick();
        check_output("rst_req_ready", 64'(req_ready), 64'd0);
        check_output("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_output("rst_wr_pulse", 64'(wr_pulse), 64'd0);
        check_output("rst_wr_index", 64'(wr_index), 64'd0);
        check_output("rst_rdata", resp_rdata, 64'd0);
        check_regs("rst");
        reset = 1'b1;
        #1;
        check_output("rst_release_ready", 64'(req_ready), 64'd1);

        // Single write with a one-cycle strobe
        apply_write(32'd3, 64'h1122334455667788);
        tick();
        check_output("wr_pulse_once", 64'(wr_pulse), 64'd0);
        check_output("wr_reg3_held", regs_out[3*DW +: DW], 64'h1122334455667788);
        check_output("wr_no_resp", 64'(resp_valid), 64'd0);

        // Read with host back-pressure
        apply_read(32'd3, 5, got);
        check_output("rd3_value", got, 64'h1122334455667788);

        // Illegal accesses and status register
        apply_write(32'd40, {$urandom, $urandom});
        apply_read(32'd99, 0, got);
        check_output("illegal_read", got, 64'd0);
        apply_read(32'd16, 0, got);
        check_output("status_two", got, 64'd2);
        apply_write(32'd16, {$urandom, $urandom});
        apply_read(32'd16, 1, got);
        check_output("status_cleared", got, 64'd0);

        // Back-to-back writes, one per cycle
        pulses    = 0;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        for (int i = 0; i < NR; i++) begin
            req_addr  = AW'(i);
            req_wdata = {$urandom, $urandom};
            check_output("b2b_ready", 64'(req_ready), 64'd1);
            tick();
            void'(model_access(req_addr, 1'b1, req_wdata));
            pulses += int'(wr_pulse);
            check_output("b2b_index", 64'(wr_index), 64'(i));
        end
        req_valid = 1'b0;
        tick();
        check_output("b2b_pulse_count", 64'(pulses), 64'(NR));
        check_output("b2b_pulse_end", 64'(wr_pulse), 64'd0);
        check_regs("b2b");

        // Randomized mixed traffic
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                7:       a = AW'(NR);
                8:       a = AW'($urandom_range(NR + 1, 255));
                9:       a = $urandom | 32'h0000_0100;
                default: a = AW'($urandom_range(0, NR - 1));
            endcase
            if ($urandom_range(0, 1) == 1) apply_write(a, {$urandom, $urandom});
            else                           apply_read(a, int'($urandom_range(0, 2)), got);
        end
        check_regs("rand");
        apply_read(AW'(NR), 0, got);

        // Error counter saturation
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = AW'(NR + 5);
        for (int i = 0; i < 70000; i++) begin
            tick();
            void'(model_access(req_addr, 1'b1, '0));
        end
        req_valid = 1'b0;
        tick();
        apply_read(AW'(NR), 0, got);
        check_output("err_saturated", got, 64'h0000_0000_0000_FFFF);

        // Reset while a response is pending
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 32'd3;
        tick();
        req_valid = 1'b0;
        check_output("pre_reset_resp", 64'(resp_valid), 64'd1);
        reset = 1'b0;
        tick();
        model_clear();
        check_output("inrst_resp_valid", 64'(resp_valid), 64'd0);
        check_output("inrst_req_ready", 64'(req_ready), 64'd0);
        check_output("inrst_wr_pulse", 64'(wr_pulse), 64'd0);
        check_regs("rst2");
        reset = 1'b1;
        #1;
        check_output("rst2_release_ready", 64'(req_ready), 64'd1);
        tick();
        check_output("no_stale_resp", 64'(resp_valid), 64'd0);
        apply_read(AW'(NR), 0, got);
        check_output("rst2_status", got, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
